// File: rtl/systolic_coef_loader.sv
// systolic_coef_loader
// Load sequencer for a systolic FIR: streams a coefficient set from an
// external synchronous memory into the filter's coefficient chain. It blocks
// and counts input samples while busy and forwards samples when idle.
// Build option: define SYSTOLIC_COEF_FLUSH_EN to add a FLUSH phase. This phase
// pushes CoeffCount zero samples after each load to clear the filter's delay line.

module systolic_coef_loader #(
  parameter int CoeffCount = 16,
  parameter int CoeffWidth = 18,
  parameter int DataWidth  = 18,
  parameter int BankBits   = 1
) (
  input  logic                                   Clk_i,
  input  logic                                   Rst_i,
  input  logic                                   Load_i,
  input  logic [BankBits-1:0]                    BankSel_i,
  output logic [BankBits+$clog2(CoeffCount)-1:0] CoeffAddr_o,
  input  logic [CoeffWidth-1:0]                  CoeffData_i,
  output logic [CoeffWidth-1:0]                  CoeffData_o,
  output logic                                   CoeffShift_o,
  input  logic [DataWidth-1:0]                   Data_i,
  input  logic                                   DataNd_i,
  output logic [DataWidth-1:0]                   FilterData_o,
  output logic                                   FilterDataNd_o,
  output logic                                   Busy_o,
  output logic                                   Done_o,
  output logic [BankBits-1:0]                    ActiveBank_o,
  output logic [15:0]                            DropCount_o
);

  localparam int                 IdxBits = $clog2(CoeffCount);
  localparam logic [IdxBits-1:0] LastIdx = IdxBits'(CoeffCount - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
`ifdef SYSTOLIC_COEF_FLUSH_EN
  localparam logic [1:0] ST_FLUSH = 2'd2;
`endif

  logic [1:0]           state_q,       state_d;
  logic [IdxBits-1:0]   idx_q,         idx_d;        // address index, reused as flush counter
  logic [BankBits-1:0]  bank_q,        bank_d;       // bank being loaded
  logic                 addr_vld_q,    addr_vld_d;   // CoeffAddr_o carries a live address
  logic                 shift_q,       shift_d;      // read data for last address is valid
  logic                 pending_q,     pending_d;    // one-deep queued load request
  logic                 done_q,        done_d;
  logic [BankBits-1:0]  active_bank_q, active_bank_d;
  logic [DataWidth-1:0] fdata_q,       fdata_d;
  logic                 fnd_q,         fnd_d;
  logic [15:0]          drop_q,        drop_d;

  logic busy;
  assign busy = (state_q != ST_IDLE);

  // Next-state logic: sequencing, pass-through, pending request, drop counter.
  always_comb begin
    // NOTE: every signal gets a default first, so no latch can be inferred.
    state_d       = state_q;
    idx_d         = idx_q;
    bank_d        = bank_q;
    addr_vld_d    = addr_vld_q;
    shift_d       = addr_vld_q;  // memory read latency is one cycle
    pending_d     = pending_q;
    done_d        = 1'b0;
    active_bank_d = active_bank_q;
    fdata_d       = fdata_q;
    fnd_d         = 1'b0;
    drop_d        = drop_q;

    unique case (state_q)
      ST_IDLE: begin
        fdata_d = Data_i;
        fnd_d   = DataNd_i;
        if (Load_i || pending_q) begin
          state_d    = ST_LOAD;
          bank_d     = BankSel_i;
          idx_d      = '0;
          addr_vld_d = 1'b1;
          pending_d  = 1'b0;
        end
      end

      ST_LOAD: begin
        if (Load_i) pending_d = 1'b1;
        if (addr_vld_q) begin
          if (idx_q == LastIdx) addr_vld_d = 1'b0;
          else                  idx_d      = idx_q + 1'b1;
        end else if (shift_q) begin
          // Last coefficient is being shifted this cycle.
`ifdef SYSTOLIC_COEF_FLUSH_EN
          state_d = ST_FLUSH;
          idx_d   = '0;
          fdata_d = '0;
          fnd_d   = 1'b1;
`else
          state_d       = ST_IDLE;
          done_d        = 1'b1;
          active_bank_d = bank_q;
`endif
        end
      end

`ifdef SYSTOLIC_COEF_FLUSH_EN
      ST_FLUSH: begin
        if (Load_i) pending_d = 1'b1;
        fdata_d = '0;
        if (idx_q == LastIdx) begin
          state_d       = ST_IDLE;
          done_d        = 1'b1;
          active_bank_d = bank_q;
        end else begin
          idx_d = idx_q + 1'b1;
          fnd_d = 1'b1;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase

    if (busy && DataNd_i && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge Clk_i) begin
    // NOTE: non-blocking assignments make every register update from pre-edge values.
    if (Rst_i) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      bank_q        <= '0;
      addr_vld_q    <= 1'b0;
      shift_q       <= 1'b0;
      pending_q     <= 1'b0;
      done_q        <= 1'b0;
      active_bank_q <= '0;
      fdata_q       <= '0;
      fnd_q         <= 1'b0;
      drop_q        <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      bank_q        <= bank_d;
      addr_vld_q    <= addr_vld_d;
      shift_q       <= shift_d;
      pending_q     <= pending_d;
      done_q        <= done_d;
      active_bank_q <= active_bank_d;
      fdata_q       <= fdata_d;
      fnd_q         <= fnd_d;
      drop_q        <= drop_d;
    end
  end

  assign CoeffAddr_o    = {bank_q, idx_q};
  assign CoeffData_o    = CoeffData_i;  // qualified downstream by CoeffShift_o
  assign CoeffShift_o   = shift_q;
  assign FilterData_o   = fdata_q;
  assign FilterDataNd_o = fnd_q;
  assign Busy_o         = busy;
  assign Done_o         = done_q;
  assign ActiveBank_o   = active_bank_q;
  assign DropCount_o    = drop_q;

endmodule

// File: tb/tb_systolic_coef_loader.sv
// Testbench for systolic_coef_loader. A synchronous memory model returns
// data == address. A scoreboard holds the expected coefficient and sample streams.
// Expected timing follows SYSTOLIC_COEF_FLUSH_EN if it is defined.

module tb_systolic_coef_loader;

  localparam int CC = 16;
  localparam int CW = 18;
  localparam int DW = 18;
  localparam int BB = 1;
  localparam int AW = BB + $clog2(CC);
`ifdef SYSTOLIC_COEF_FLUSH_EN
  localparam int DONE_AT = 2 * CC + 2;
  localparam int EXP_FLUSH_STROBES = CC;
`else
  localparam int DONE_AT = CC + 2;
  localparam int EXP_FLUSH_STROBES = 0;
`endif
  localparam int SAT_CYCLES = 74200;

  logic          Clk_i = 1'b0;
  logic          Rst_i;
  logic          Load_i;
  logic [BB-1:0] BankSel_i;
  logic [AW-1:0] CoeffAddr_o;
  logic [CW-1:0] CoeffData_i;
  logic [CW-1:0] CoeffData_o;
  logic          CoeffShift_o;
  logic [DW-1:0] Data_i;
  logic          DataNd_i;
  logic [DW-1:0] FilterData_o;
  logic          FilterDataNd_o;
  logic          Busy_o;
  logic          Done_o;
  logic [BB-1:0] ActiveBank_o;
  logic [15:0]   DropCount_o;

  logic [CW-1:0] mem_q;

  int vectors     = 0;
  int miscompares = 0;
  int exp_drop    = 0;
  bit sb_en       = 1'b0;

  logic [DW-1:0] exp_samp[$];
  logic [CW-1:0] exp_coef[$];
  logic [DW-1:0] se;
  logic [CW-1:0] ce;

  systolic_coef_loader #(
    .CoeffCount(CC), .CoeffWidth(CW), .DataWidth(DW), .BankBits(BB)
  ) dut (
    .Clk_i(Clk_i), .Rst_i(Rst_i), .Load_i(Load_i), .BankSel_i(BankSel_i),
    .CoeffAddr_o(CoeffAddr_o), .CoeffData_i(CoeffData_i), .CoeffData_o(CoeffData_o),
    .CoeffShift_o(CoeffShift_o), .Data_i(Data_i), .DataNd_i(DataNd_i),
    .FilterData_o(FilterData_o), .FilterDataNd_o(FilterDataNd_o), .Busy_o(Busy_o),
    .Done_o(Done_o), .ActiveBank_o(ActiveBank_o), .DropCount_o(DropCount_o)
  );

  always #5 Clk_i = ~Clk_i;

  // Synchronous memory: one-cycle read latency, contents equal to the address.
  always @(posedge Clk_i) mem_q <= CW'(CoeffAddr_o);
  assign CoeffData_i = mem_q;

  // Scoreboard consumer: compares every strobe against the expected queues.
  always @(negedge Clk_i) begin
    if (sb_en && FilterDataNd_o === 1'b1) begin
      vectors++;
      if (exp_samp.size() == 0) begin
        miscompares++;
        $display("FAIL sample_stream: unexpected strobe, got %0d, expected no strobe", FilterData_o);
      end else begin
        se = exp_samp.pop_front();
        if (FilterData_o !== se) begin
          miscompares++;
          $display("FAIL sample_stream: got %0d, expected %0d", FilterData_o, se);
        end
      end
    end
    if (sb_en && CoeffShift_o === 1'b1) begin
      vectors++;
      if (exp_coef.size() == 0) begin
        miscompares++;
        $display("FAIL coef_stream: unexpected shift, got %0d, expected no shift", CoeffData_o);
      end else begin
        ce = exp_coef.pop_front();
        if (CoeffData_o !== ce) begin
          miscompares++;
          $display("FAIL coef_stream: got %0d, expected %0d", CoeffData_o, ce);
        end
      end
    end
  end

  task automatic step();
    @(posedge Clk_i);
    #1;
  endtask

  // Queue the coefficient stream (and flush zeros) a load of this bank must produce.
  task automatic push_load(input int bank);
    for (int i = 0; i < CC; i++) exp_coef.push_back(CW'(bank * CC + i));
`ifdef SYSTOLIC_COEF_FLUSH_EN
    for (int i = 0; i < CC; i++) exp_samp.push_back('0);
`endif
  endtask

  task automatic test_drained(input string name);
    vectors++;
    if (exp_coef.size() != 0 || exp_samp.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drained: got %0d coef / %0d samples left, expected 0 / 0",
               name, exp_coef.size(), exp_samp.size());
    end
  endtask

  task automatic test_reset();
    Rst_i = 1'b1;
    repeat (2) step();
    vectors++;
    if ({Busy_o, Done_o, CoeffShift_o, FilterDataNd_o} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b, expected 0000", {Busy_o, Done_o, CoeffShift_o, FilterDataNd_o});
    end
    vectors++;
    if (FilterData_o !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got %0d, expected 0", FilterData_o);
    end
    vectors++;
    if (ActiveBank_o !== '0 || DropCount_o !== 16'd0 || CoeffAddr_o !== '0) begin
      miscompares++;
      $display("FAIL reset_regs: got bank %0d drop %0d addr %0d, expected 0 0 0",
               ActiveBank_o, DropCount_o, CoeffAddr_o);
    end
    Rst_i = 1'b0;
    step();
    sb_en = 1'b1;
  endtask

  task automatic test_passthrough();
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k > 1) begin
        vectors++;
        if (FilterDataNd_o !== 1'b1 || FilterData_o !== DW'(k - 1)) begin
          miscompares++;
          $display("FAIL passthru_latency: got nd %b data %0d, expected 1 %0d", FilterDataNd_o, FilterData_o, k - 1);
        end
      end
      Data_i   = DW'(k);
      DataNd_i = 1'b1;
      exp_samp.push_back(DW'(k));
    end
    step();
    vectors++;
    if (FilterDataNd_o !== 1'b1 || FilterData_o !== DW'(5)) begin
      miscompares++;
      $display("FAIL passthru_last: got nd %b data %0d, expected 1 5", FilterDataNd_o, FilterData_o);
    end
    DataNd_i = 1'b0;
    step();
    vectors++;
    if ({FilterDataNd_o, Done_o, Busy_o} !== 3'b000 || DropCount_o !== 16'd0) begin
      miscompares++;
      $display("FAIL passthru_idle: got nd/done/busy %b drop %0d, expected 000 0",
               {FilterDataNd_o, Done_o, Busy_o}, DropCount_o);
    end
    test_drained("passthru");
  endtask

  task automatic test_load_bank1();
    logic [2:0] exp_flags;
    step();
    Load_i    = 1'b1;
    BankSel_i = 1'b1;
    push_load(1);
    for (int c = 1; c <= DONE_AT + 1; c++) begin
      step();
      Load_i    = 1'b0;
      BankSel_i = 1'b0;
      exp_flags = {c < DONE_AT, (c >= 2) && (c <= CC + 1), c == DONE_AT};
      vectors++;
      if ({Busy_o, CoeffShift_o, Done_o} !== exp_flags) begin
        miscompares++;
        $display("FAIL load_timing: cycle T+%0d got busy/shift/done %b, expected %b",
                 c, {Busy_o, CoeffShift_o, Done_o}, exp_flags);
      end
      if (c <= CC) begin
        vectors++;
        if (CoeffAddr_o !== AW'(CC + c - 1)) begin
          miscompares++;
          $display("FAIL load_addr: cycle T+%0d got %0d, expected %0d", c, CoeffAddr_o, CC + c - 1);
        end
      end
      if (c == DONE_AT) begin
        vectors++;
        if (ActiveBank_o !== 1'b1) begin
          miscompares++;
          $display("FAIL load_active_bank: got %0d, expected 1", ActiveBank_o);
        end
      end
    end
    test_drained("load");
  endtask

  task automatic test_drop_during_load();
    int nd_cnt = 0;
    step();
    Load_i    = 1'b1;
    BankSel_i = 1'b0;
    DataNd_i  = 1'b0;
    push_load(0);
    for (int c = 1; c <= DONE_AT + 1; c++) begin
      step();
      if (c <= DONE_AT && FilterDataNd_o === 1'b1) nd_cnt++;
      Load_i   = 1'b0;
      DataNd_i = (c >= 2) && (c <= 11);
      Data_i   = DW'($urandom_range(1, 1000));
    end
    exp_drop += 10;
    vectors++;
    if (nd_cnt != EXP_FLUSH_STROBES) begin
      miscompares++;
      $display("FAIL drop_strobes: got %0d filter strobes, expected %0d", nd_cnt, EXP_FLUSH_STROBES);
    end
    vectors++;
    if (DropCount_o !== 16'(exp_drop)) begin
      miscompares++;
      $display("FAIL drop_count: got %0d, expected %0d", DropCount_o, exp_drop);
    end
    test_drained("drop");
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    int d1 = -1;
    int d2 = -1;
    step();
    Load_i    = 1'b1;
    BankSel_i = 1'b0;
    push_load(0);
    for (int c = 1; c <= 2 * DONE_AT + 3; c++) begin
      step();
      if (Done_o === 1'b1) begin
        dones++;
        if (dones == 1) d1 = c;
        else            d2 = c;
      end
      if (c == DONE_AT) begin
        vectors++;
        if (Busy_o !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_dip: got busy %b at done cycle, expected 0", Busy_o);
        end
        push_load(1);
      end
      if (c == DONE_AT + 1) begin
        vectors++;
        if (Busy_o !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_restart: got busy %b after done, expected 1", Busy_o);
        end
      end
      Load_i    = (c == 3) || (c == 5) || (c == 7);
      BankSel_i = BB'(c >= DONE_AT);
    end
    Load_i = 1'b0;
    vectors++;
    if (dones != 2 || d1 != DONE_AT || d2 != 2 * DONE_AT) begin
      miscompares++;
      $display("FAIL b2b_done: got %0d pulses at T+%0d,T+%0d, expected 2 at T+%0d,T+%0d",
               dones, d1, d2, DONE_AT, 2 * DONE_AT);
    end
    vectors++;
    if (ActiveBank_o !== 1'b1 || Busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_final: got bank %0d busy %b, expected 1 0", ActiveBank_o, Busy_o);
    end
    test_drained("b2b");
  endtask

  task automatic test_reset_mid_load();
    step();
    Load_i    = 1'b1;
    BankSel_i = 1'b1;
    push_load(1);
    for (int c = 1; c <= 8; c++) begin
      step();
      Load_i = 1'b0;
      if (c == 8) begin
        vectors++;
        if (CoeffAddr_o !== AW'(CC + 7)) begin
          miscompares++;
          $display("FAIL rst_mid_addr: got %0d, expected %0d", CoeffAddr_o, CC + 7);
        end
        Rst_i = 1'b1;
      end
    end
    step();
    vectors++;
    if ({CoeffShift_o, Busy_o, FilterDataNd_o, Done_o} !== 4'b0000) begin
      miscompares++;
      $display("FAIL rst_mid_flags: got shift/busy/nd/done %b, expected 0000",
               {CoeffShift_o, Busy_o, FilterDataNd_o, Done_o});
    end
    vectors++;
    if (ActiveBank_o !== '0 || DropCount_o !== 16'd0 || CoeffAddr_o !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_regs: got bank %0d drop %0d addr %0d, expected 0 0 0",
               ActiveBank_o, DropCount_o, CoeffAddr_o);
    end
    vectors++;
    if (exp_coef.size() != CC - 7) begin
      miscompares++;
      $display("FAIL rst_mid_shifts: got %0d shifts, expected 7", CC - exp_coef.size());
    end
    exp_coef.delete();
    exp_samp.delete();
    exp_drop = 0;
    Rst_i    = 1'b0;
    step();
    Load_i    = 1'b1;
    BankSel_i = 1'b1;
    push_load(1);
    for (int c = 1; c <= DONE_AT; c++) begin
      step();
      Load_i = 1'b0;
      if (c == 1) begin
        vectors++;
        if (CoeffAddr_o !== AW'(CC)) begin
          miscompares++;
          $display("FAIL rst_reload_addr: got %0d, expected %0d", CoeffAddr_o, CC);
        end
      end
    end
    vectors++;
    if (Done_o !== 1'b1 || ActiveBank_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_reload_done: got done %b bank %0d, expected 1 1", Done_o, ActiveBank_o);
    end
    test_drained("rst_reload");
  endtask

  task automatic test_saturation();
    int mid;
    sb_en = 1'b0;
    mid   = 10 * DONE_AT + 5;
    step();
    Load_i    = 1'b1;
    BankSel_i = 1'b0;
    DataNd_i  = 1'b1;
    for (int c = 1; c <= SAT_CYCLES; c++) begin
      step();
      if (c == mid) begin
        vectors++;
        if (DropCount_o !== 16'(exp_drop + (c - 1) - (c - 1) / DONE_AT)) begin
          miscompares++;
          $display("FAIL sat_midway: got %0d, expected %0d", DropCount_o,
                   exp_drop + (c - 1) - (c - 1) / DONE_AT);
        end
      end
    end
    Load_i   = 1'b0;
    DataNd_i = 1'b0;
    repeat (2 * DONE_AT + 4) step();
    vectors++;
    if (Busy_o !== 1'b0 || DropCount_o !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL sat_hold: got busy %b drop %h, expected 0 ffff", Busy_o, DropCount_o);
    end
  endtask

  initial begin
    Rst_i     = 1'b1;
    Load_i    = 1'b0;
    BankSel_i = '0;
    Data_i    = '0;
    DataNd_i  = 1'b0;
    test_reset();
    test_passthrough();
    test_load_bank1();
    test_drop_during_load();
    test_back_to_back();
    test_reset_mid_load();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/systolic_coef_loader.md
# systolic_coef_loader

Load sequencer for the 16-tap systolic FIR path. It reads a coefficient set from an external synchronous ROM/RAM bank and shifts it serially into the filter's coefficient chain. While loading, it blocks and counts incoming samples. With the flush option compiled in, it then pushes zero samples to clear the filter's delay line. The block sits between the sample source and the systolic filter block and owns the filter's sample-strobe and coefficient-shift inputs.

## Interface
- CoeffCount, 16, number of taps; also the number of flush samples.
- CoeffWidth, 18, coefficient width.
- DataWidth, 18, sample width.
- BankBits, 1, bank-select width; the external memory holds 2^BankBits sets.
- Clk_i  in  1  single clock; all logic on its rising edge.
- Rst_i  in  1  synchronous, active-high reset.
- Load_i  in  1  request to load bank BankSel_i; single-cycle pulse or level.
- BankSel_i  in  BankBits  bank to load; sampled when a request is accepted.
- CoeffAddr_o  out  BankBits+clog2(CoeffCount)  memory address {bank, index}.
- CoeffData_i  in  CoeffWidth  memory read data; valid 1 cycle after the address.
- CoeffData_o  out  CoeffWidth  coefficient to the filter chain.
- CoeffShift_o  out  1  shift-enable for the filter coefficient chain.
- Data_i  in  DataWidth  input sample.
- DataNd_i  in  1  input sample strobe.
- FilterData_o  out  DataWidth  sample to the filter.
- FilterDataNd_o  out  1  sample strobe to the filter.
- Busy_o  out  1  high in LOAD and FLUSH.
- Done_o  out  1  one-cycle pulse when a load sequence completes.
- ActiveBank_o  out  BankBits  bank currently resident in the filter.
- DropCount_o  out  16  saturating count of samples dropped while busy.

## Operation
- States: IDLE, LOAD, FLUSH (FLUSH exists only with the macro defined).
- IDLE:
  - Registered pass-through: FilterData_o <= Data_i; FilterDataNd_o <= DataNd_i.
  - Load_i=1 or pending=1 → LOAD. BankSel_i is latched into bankReg. Index counter is cleared to 0. Pending is cleared.
- LOAD:
  - CoeffAddr_o = {bankReg, idx}. idx increments every cycle from 0 to CoeffCount-1.
  - Read data returns 1 cycle later. CoeffShift_o is a 1-cycle-delayed copy of the address-valid signal; CoeffData_o = CoeffData_i registered? No: CoeffData_o = CoeffData_i (combinational), qualified by CoeffShift_o.
  - Address index 0 is shifted in first and ends at the far tap.
  - Sequence ends after the last shift → FLUSH (macro) or IDLE.
- FLUSH: FilterData_o=0 and FilterDataNd_o=1 for exactly CoeffCount cycles, then → IDLE.
- On return to IDLE: Done_o pulses 1 cycle and ActiveBank_o <= bankReg.
- While Busy_o: DataNd_i samples are not forwarded (FilterDataNd_o=0 except flush strobes). DropCount_o increments per dropped strobe and saturates at 0xFFFF. It clears only on reset.
- Load_i while Busy_o sets a one-deep pending flag. BankSel_i is re-sampled when the pending load starts. Further requests while pending is set are discarded.
- Load_i and DataNd_i in the same IDLE cycle: the sample is forwarded and the load starts next cycle.

## Timing
- Reset values:
  - state=IDLE, pending=0.
  - CoeffShift_o=0, FilterDataNd_o=0, FilterData_o=0, CoeffData_o don't-care.
  - Busy_o=0, Done_o=0, ActiveBank_o=0, DropCount_o=0, CoeffAddr_o=0.
- Pass-through latency: 1 cycle.
- Load accepted at cycle T:
  - Busy_o=1 from T+1.
  - Addresses on T+1..T+CoeffCount.
  - CoeffShift_o=1 on T+2..T+CoeffCount+1.
- Without the macro: Done_o at T+CoeffCount+2; Busy_o low and pass-through resumes the same cycle.
- With the macro: flush strobes on T+CoeffCount+2..T+2·CoeffCount+1; Done_o at T+2·CoeffCount+2.
- Reset mid-sequence: all outputs return to reset values the next cycle and pending is lost. The filter coefficients are then undefined, and the owner must issue a new Load_i.
- A pending load starts in the cycle after Done_o (Busy_o dips low for exactly that cycle).

## Configuration
- SYSTOLIC_COEF_FLUSH_EN defined: the FLUSH state is built in. CoeffCount zero samples follow every load, so the first output after Done_o reflects only post-load samples.
- Not defined: LOAD → IDLE directly. Stale history mixes with the new coefficients for CoeffCount samples.

## Test plan
- Reset, then a 5-sample stream 1..5 with DataNd_i=1 → FilterData_o=1..5, each 1 cycle later; Done_o=0, DropCount_o=0.
- Memory loaded with value=address; Load_i with BankSel_i=1 → CoeffAddr_o 16..31 on T+1..T+16; CoeffShift_o high 16 cycles carrying 16..31; ActiveBank_o=1 at Done_o (T+18, or T+34 with the macro).
- Macro defined, 10 DataNd_i strobes during a load → FilterDataNd_o only for the 16 flush zeros; DropCount_o=10.
- Load_i asserted 3 times during an active load → exactly one extra sequence starts the cycle after Done_o; two Done_o pulses total.
- Rst_i asserted at LOAD index 7 → CoeffShift_o=0, Busy_o=0 next cycle; ActiveBank_o=0; the next Load_i restarts from index 0.
- 70000 strobes dropped across repeated loads → DropCount_o holds 0xFFFF.
